game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game controller for the falling-block game.
- Sequences the piece datapath through spawn, gravity fall, player moves, lock, line-clear handshake and game-over.
- Sits between the debounced push-buttons and the new-block generator / board datapath inside top.
- Owns gravity timing, which speeds up with level, and tracks lines and level.

Parameters:
- FALL_TICKS, 50: gravity period in clk cycles at level 0 (0.5 s at hz100); range 2..255.
- MIN_FALL_TICKS, 10: floor on gravity period; range 1..FALL_TICKS.
- LEVEL_STEP, 4: cycles removed from the gravity period per level.

Ports:
- clk  input  1  system clock (hz100 in top); the only clock.
- nRst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  start/restart button; synchronous, debounced level.
- left_i  input  1  move-left button; level.
- right_i  input  1  move-right button; level.
- rotate_i  input  1  rotate button; level.
- collide_down_i  input  1  datapath: the active piece cannot move down.
- collide_spawn_i  input  1  datapath: the freshly spawned piece overlaps the board.
- clear_done_i  input  1  line-clear unit has finished; qualifies lines_i.
- lines_i  input  3  number of rows cleared (0..4); valid when clear_done_i is high.
- spawn_o  output  1  one-cycle pulse: generator emits a new block.
- drop_o  output  1  one-cycle pulse: move piece down one row.
- move_left_o  output  1  one-cycle pulse: shift piece left.
- move_right_o  output  1  one-cycle pulse: shift piece right.
- rotate_o  output  1  one-cycle pulse: rotate piece.
- lock_o  output  1  one-cycle pulse: merge piece into the board.
- clear_req_o  output  1  level request to the line-clear unit.
- state_o  output  3  current state encoding.
- lines_o  output  8  total cleared lines; saturates at 255.
- level_o  output  4  min(15, lines_o >> 2).

Behaviour:
- Reset (async, nRst_i=0):
  - state=IDLE; all pulses, clear_req_o, lines_o, level_o, fall counter and edge-detect flops are 0.
  - Reset mid-operation abandons everything, including an outstanding clear_req_o.
- Edge detection: one flop per button; edge = in & ~in_q. A button held through reset release produces one edge on the first clock.
- Timing convention: all outputs are registered. A decision taken at clock edge k, using pre-edge values, is visible from k until k+1. Pulses last exactly one cycle.
- IDLE (0): start edge -> clear lines/level -> SPAWN.
- SPAWN (1): spawn_o=1 for this cycle -> SPAWN_CHK.
- SPAWN_CHK (2): collide_spawn_i=1 -> GAMEOVER; else -> FALL with fall_cnt=0.
- FALL (3):
  - fall_cnt increments each cycle.
  - period = max(MIN_FALL_TICKS, FALL_TICKS - LEVEL_STEP*level_o), computed in 8 bits with no underflow.
  - At fall_cnt==period-1:
    - collide_down_i=1 -> LOCK.
    - Otherwise drop_o pulses and fall_cnt returns to 0.
  - Button edges (only when no gravity event this cycle): issue one pulse with priority rotate > left > right; losing edges are discarded, not queued.
  - A button edge in the same cycle as a gravity event is discarded.
- LOCK (4): lock_o=1 for this cycle -> CLEAR, with clear_req_o asserted from entry.
- CLEAR (5):
  - clear_req_o held high until clear_done_i is sampled high.
  - On that cycle: lines_o += lines_i (saturating at 255), level_o recomputed, clear_req_o drops -> SPAWN.
  - clear_done_i outside CLEAR is ignored.
- GAMEOVER (6): outputs idle; lines/level held; start edge -> IDLE.
- Encoding 7 is unreachable and recovers to IDLE.
- Buttons other than start are ignored in all states except FALL.

Decomposition:
- game_pkg holds:
  - state_t enum: IDLE=0, SPAWN=1, SPAWN_CHK=2, FALL=3, LOCK=4, CLEAR=5, GAMEOVER=6.
  - Constants MAX_LEVEL=15 and LINES_PER_LEVEL=4.
- One sub-module, btn_edge: a parameterised-width rising-edge detector with async active-low reset, instantiated once for the 4 buttons.

Test Plan:
- Params FALL_TICKS=5, MIN=2, STEP=1 for all scenarios.
- Reset and start: reset mid-FALL -> all outputs 0, state_o=0. start_i high 1 cycle -> state_o 1 with spawn_o=1 for one cycle, then 2, then 3.
- Gravity, no collision: FALL with collide_down_i=0 -> drop_o every 5 cycles. Holding left_i -> exactly one move_left_o.
- Move arbitration: left_i, right_i and rotate_i rise together -> only rotate_o. An edge coinciding with a drop cycle -> no move pulse.
- Lock and clear:
  - Raise collide_down_i -> lock_o at the period boundary, then clear_req_o high.
  - Hold clear_done_i low 3 cycles -> clear_req_o stays high.
  - Then clear_done_i=1 with lines_i=4 -> lines_o=4, level_o=1, drop period becomes 4, spawn_o follows.
- Saturation: 64 clears of 4 lines -> lines_o=255, level_o=15, period=MIN=2.
- Game over: collide_spawn_i=1 in SPAWN_CHK -> state_o=6, no drops. start edge -> IDLE; next start edge -> lines_o=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the falling-block game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN     = 3'd1,
    SPAWN_CHK = 3'd2,
    FALL      = 3'd3,
    LOCK      = 3'd4,
    CLEAR     = 3'd5,
    GAMEOVER  = 3'd6
  } state_t;

  localparam int MAX_LEVEL       = 15;
  localparam int LINES_PER_LEVEL = 4;

  function automatic logic [3:0] level_of(input logic [7:0] lines);
    logic [7:0] q;
    q = lines / 8'(LINES_PER_LEVEL);
    if (q > 8'(MAX_LEVEL)) return 4'(MAX_LEVEL);
    return q[3:0];
  endfunction

  // Signed int arithmetic keeps the subtraction from wrapping below the floor.
  function automatic logic [7:0] fall_period(input logic [3:0] level,
                                             input int fall_ticks,
                                             input int min_ticks,
                                             input int step);
    int dec;
    dec = step * int'(level);
    if (fall_ticks - dec <= min_ticks) return 8'(min_ticks);
    return 8'(fall_ticks - dec);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of the sequencer <-> piece datapath / line-clear signals.
interface game_sequencer_if;
  // clear_req is a level request held until clear_done is sampled high;
  // lines is only meaningful in the cycle clear_done is high.
  logic       collide_down;
  logic       collide_spawn;
  logic       clear_done;
  logic [2:0] lines;
  logic       spawn;
  logic       drop;
  logic       move_left;
  logic       move_right;
  logic       rotate;
  logic       lock;
  logic       clear_req;

  modport master (
    output spawn, drop, move_left, move_right, rotate, lock, clear_req,
    input  collide_down, collide_spawn, clear_done, lines
  );

  modport slave (
    input  spawn, drop, move_left, move_right, rotate, lock, clear_req,
    output collide_down, collide_spawn, clear_done, lines
  );
endinterface

// File: rtl/game_sequencer_btn_edge.sv
// Rising-edge detector, one flop per input bit.
module btn_edge #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nRst_i,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] btn_q;

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) btn_q <= '0;
    else         btn_q <= btn_i;
  end

  assign edge_o = btn_i & ~btn_q;

endmodule

// File: rtl/game_sequencer.sv
// Game controller: spawn, gravity, player moves, lock, line-clear handshake
// and game-over, with level-dependent gravity period.
module game_sequencer
  import game_pkg::*;
#(
  parameter int FALL_TICKS     = 50,
  parameter int MIN_FALL_TICKS = 10,
  parameter int LEVEL_STEP     = 4
) (
  input  logic       clk,
  input  logic       nRst_i,
  input  logic       start_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       rotate_i,
  input  logic       collide_down_i,
  input  logic       collide_spawn_i,
  input  logic       clear_done_i,
  input  logic [2:0] lines_i,
  output logic       spawn_o,
  output logic       drop_o,
  output logic       move_left_o,
  output logic       move_right_o,
  output logic       rotate_o,
  output logic       lock_o,
  output logic       clear_req_o,
  output logic [2:0] state_o,
  output logic [7:0] lines_o,
  output logic [3:0] level_o
);

  state_t     state_q, state_d;
  logic [7:0] fall_cnt_q, fall_cnt_d;
  logic [7:0] lines_q, lines_d;
  logic [3:0] level_q, level_d;
  logic       spawn_q, spawn_d;
  logic       drop_q, drop_d;
  logic       left_q, left_d;
  logic       right_q, right_d;
  logic       rot_q, rot_d;
  logic       lock_q, lock_d;
  logic       clear_req_q, clear_req_d;

  logic [3:0] btn_edges;
  logic       start_edge, rot_edge, left_edge, right_edge;
  logic [7:0] period;
  logic       grav;
  logic [8:0] lines_sum;

  btn_edge #(.WIDTH(4)) u_btn_edge (
    .clk    (clk),
    .nRst_i (nRst_i),
    .btn_i  ({start_i, rotate_i, left_i, right_i}),
    .edge_o (btn_edges)
  );

  assign {start_edge, rot_edge, left_edge, right_edge} = btn_edges;

  assign period    = fall_period(level_q, FALL_TICKS, MIN_FALL_TICKS, LEVEL_STEP);
  assign grav      = (fall_cnt_q == period - 8'd1);
  assign lines_sum = {1'b0, lines_q} + {6'd0, lines_i};

  always_comb begin
    state_d     = state_q;
    fall_cnt_d  = fall_cnt_q;
    lines_d     = lines_q;
    level_d     = level_q;
    spawn_d     = 1'b0;
    drop_d      = 1'b0;
    left_d      = 1'b0;
    right_d     = 1'b0;
    rot_d       = 1'b0;
    lock_d      = 1'b0;
    clear_req_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          lines_d = '0;
          level_d = '0;
          state_d = SPAWN;
          spawn_d = 1'b1;
        end
      end
      SPAWN: state_d = SPAWN_CHK;
      SPAWN_CHK: begin
        if (collide_spawn_i) begin
          state_d = GAMEOVER;
        end else begin
          state_d    = FALL;
          fall_cnt_d = '0;
        end
      end
      FALL: begin
        // A gravity tick swallows any button edge arriving in the same cycle.
        if (grav) begin
          if (collide_down_i) begin
            state_d = LOCK;
            lock_d  = 1'b1;
          end else begin
            drop_d     = 1'b1;
            fall_cnt_d = '0;
          end
        end else begin
          fall_cnt_d = fall_cnt_q + 8'd1;
          if (rot_edge)        rot_d   = 1'b1;
          else if (left_edge)  left_d  = 1'b1;
          else if (right_edge) right_d = 1'b1;
        end
      end
      LOCK: begin
        state_d     = CLEAR;
        clear_req_d = 1'b1;
      end
      CLEAR: begin
        if (clear_done_i) begin
          lines_d = lines_sum[8] ? 8'hFF : lines_sum[7:0];
          level_d = level_of(lines_d);
          state_d = SPAWN;
          spawn_d = 1'b1;
        end else begin
          clear_req_d = 1'b1;
        end
      end
      GAMEOVER: begin
        if (start_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      state_q     <= IDLE;
      fall_cnt_q  <= '0;
      lines_q     <= '0;
      level_q     <= '0;
      spawn_q     <= 1'b0;
      drop_q      <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      rot_q       <= 1'b0;
      lock_q      <= 1'b0;
      clear_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fall_cnt_q  <= fall_cnt_d;
      lines_q     <= lines_d;
      level_q     <= level_d;
      spawn_q     <= spawn_d;
      drop_q      <= drop_d;
      left_q      <= left_d;
      right_q     <= right_d;
      rot_q       <= rot_d;
      lock_q      <= lock_d;
      clear_req_q <= clear_req_d;
    end
  end

  assign spawn_o      = spawn_q;
  assign drop_o       = drop_q;
  assign move_left_o  = left_q;
  assign move_right_o = right_q;
  assign rotate_o     = rot_q;
  assign lock_o       = lock_q;
  assign clear_req_o  = clear_req_q;
  assign state_o      = state_q;
  assign lines_o      = lines_q;
  assign level_o      = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer with FALL_TICKS=5, MIN=2, STEP=1.
module tb_game_sequencer;

  localparam int W = 22;
  localparam logic [5:0] P_SPAWN = 6'b100000;
  localparam logic [5:0] P_DROP  = 6'b010000;
  localparam logic [5:0] P_LEFT  = 6'b001000;
  localparam logic [5:0] P_ROT   = 6'b000010;
  localparam logic [5:0] P_LOCK  = 6'b000001;

  typedef struct packed {
    logic [15:0] at;
    logic [2:0]  st;
    logic [7:0]  lines;
    logic [3:0]  lvl;
    logic        creq;
    logic        chk_p;
  } snap_t;

  logic       clk = 1'b0;
  logic       nRst_i;
  logic       start_i, left_i, right_i, rotate_i;
  logic [2:0] state_o;
  logic [7:0] lines_o;
  logic [3:0] level_o;

  game_sequencer_if dp_if ();

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;
  logic [W-1:0] exp_q[$];
  snap_t snap_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_sequencer #(.FALL_TICKS(5), .MIN_FALL_TICKS(2), .LEVEL_STEP(1)) dut (
    .clk             (clk),
    .nRst_i          (nRst_i),
    .start_i         (start_i),
    .left_i          (left_i),
    .right_i         (right_i),
    .rotate_i        (rotate_i),
    .collide_down_i  (dp_if.collide_down),
    .collide_spawn_i (dp_if.collide_spawn),
    .clear_done_i    (dp_if.clear_done),
    .lines_i         (dp_if.lines),
    .spawn_o         (dp_if.spawn),
    .drop_o          (dp_if.drop),
    .move_left_o     (dp_if.move_left),
    .move_right_o    (dp_if.move_right),
    .rotate_o        (dp_if.rotate),
    .lock_o          (dp_if.lock),
    .clear_req_o     (dp_if.clear_req),
    .state_o         (state_o),
    .lines_o         (lines_o),
    .level_o         (level_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic ev(input int at, input logic [5:0] p);
    exp_q.push_back({16'(at), p});
  endtask

  task automatic snap(input logic [2:0] st, input logic [7:0] ln, input logic [3:0] lv,
                      input logic cr, input logic chk_p);
    snap_t s;
    s.at = 16'(cyc); s.st = st; s.lines = ln; s.lvl = lv; s.creq = cr; s.chk_p = chk_p;
    snap_q.push_back(s);
  endtask

  function automatic int period_of(input int lv);
    return (lv >= 3) ? 2 : 5 - lv;
  endfunction

  // Lock at gravity cycle g, hold clear_done low for 'hold' cycles, then finish
  // the clear with ln lines; 'over' makes the next spawn collide.
  task automatic do_clear(input int g, input int hold, input logic [2:0] ln,
                          input logic [7:0] ol, input logic [3:0] olv,
                          input logic [7:0] nl, input logic [3:0] nlv,
                          input bit over, output int f_next);
    dp_if.collide_down = 1'b1;
    ev(g, P_LOCK);
    wait_until(g);
    snap(3'd4, ol, olv, 1'b0, 1'b0);
    tick();
    dp_if.collide_down = 1'b0;
    snap(3'd5, ol, olv, 1'b1, 1'b0);
    repeat (hold) begin
      tick();
      snap(3'd5, ol, olv, 1'b1, 1'b0);
    end
    dp_if.clear_done = 1'b1;
    dp_if.lines = ln;
    dp_if.collide_spawn = over;
    ev(cyc + 1, P_SPAWN);
    tick();
    dp_if.clear_done = 1'b0;
    dp_if.lines = 3'd0;
    snap(3'd1, nl, nlv, 1'b0, 1'b0);
    tick();
    snap(3'd2, nl, nlv, 1'b0, 1'b0);
    tick();
    snap(over ? 3'd6 : 3'd3, nl, nlv, 1'b0, 1'b0);
    dp_if.collide_spawn = 1'b0;
    f_next = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f;
    nRst_i = 1'b0;
    start_i = 0; left_i = 0; right_i = 0; rotate_i = 0;
    dp_if.collide_down = 0; dp_if.collide_spawn = 0; dp_if.clear_done = 0; dp_if.lines = 3'd0;
    tick();
    snap(3'd0, 8'd0, 4'd0, 1'b0, 1'b1);
    tick();
    nRst_i = 1'b1;
    tick();

    // start -> SPAWN -> SPAWN_CHK -> FALL
    start_i = 1'b1;
    ev(cyc + 1, P_SPAWN);
    tick();
    start_i = 1'b0;
    snap(3'd1, 8'd0, 4'd0, 1'b0, 1'b0);
    tick();
    snap(3'd2, 8'd0, 4'd0, 1'b0, 1'b0);
    tick();
    snap(3'd3, 8'd0, 4'd0, 1'b0, 1'b0);
    f = cyc;

    // gravity every 5 cycles; held left gives one pulse
    tick();
    left_i = 1'b1;
    ev(f + 2, P_LEFT);
    ev(f + 5, P_DROP);
    ev(f + 10, P_DROP);
    wait_until(f + 11);
    left_i = 1'b0;
    tick();
    left_i = 1'b1; right_i = 1'b1; rotate_i = 1'b1;
    ev(f + 13, P_ROT);
    tick();
    left_i = 1'b0; right_i = 1'b0; rotate_i = 1'b0;
    ev(f + 15, P_DROP);
    wait_until(f + 19);
    right_i = 1'b1;
    ev(f + 20, P_DROP);
    wait_until(f + 21);
    right_i = 1'b0;
    wait_until(f + 22);

    // first clear: 3 cycles of waiting, then 4 lines
    do_clear(f + 25, 3, 3'd4, 8'd0, 4'd0, 8'd4, 4'd1, 1'b0, f);

    // clear_done outside CLEAR is ignored; period is now 4
    tick();
    dp_if.clear_done = 1'b1;
    dp_if.lines = 3'd3;
    tick();
    dp_if.clear_done = 1'b0;
    dp_if.lines = 3'd0;
    ev(f + 4, P_DROP);
    ev(f + 8, P_DROP);
    wait_until(f + 9);
    snap(3'd3, 8'd4, 4'd1, 1'b0, 1'b0);
    do_clear(f + 12, 0, 3'd4, 8'd4, 4'd1, 8'd8, 4'd2, 1'b0, f);

    // saturate at 64 clears of 4 lines
    for (int k = 3; k <= 64; k++) begin
      int ol, nl;
      ol = 4 * (k - 1);
      nl = (4 * k > 255) ? 255 : 4 * k;
      do_clear(f + period_of(ol / 4 > 15 ? 15 : ol / 4), 0, 3'd4,
               8'(ol), 4'(ol / 4 > 15 ? 15 : ol / 4),
               8'(nl), 4'(nl / 4 > 15 ? 15 : nl / 4), 1'b0, f);
    end
    snap(3'd3, 8'd255, 4'd15, 1'b0, 1'b0);
    ev(f + 2, P_DROP);
    ev(f + 4, P_DROP);
    ev(f + 6, P_DROP);
    wait_until(f + 7);

    // game over via spawn collision
    do_clear(f + 8, 0, 3'd0, 8'd255, 4'd15, 8'd255, 4'd15, 1'b1, f);
    repeat (10) tick();
    snap(3'd6, 8'd255, 4'd15, 1'b0, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    snap(3'd0, 8'd255, 4'd15, 1'b0, 1'b1);
    tick();
    start_i = 1'b1;
    ev(cyc + 1, P_SPAWN);
    tick();
    start_i = 1'b0;
    snap(3'd1, 8'd0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    snap(3'd3, 8'd0, 4'd0, 1'b0, 1'b0);

    // reset mid-FALL with start held through release
    tick();
    tick();
    nRst_i = 1'b0;
    start_i = 1'b1;
    #1;
    snap(3'd0, 8'd0, 4'd0, 1'b0, 1'b1);
    tick();
    nRst_i = 1'b1;
    ev(cyc + 1, P_SPAWN);
    tick();
    snap(3'd1, 8'd0, 4'd0, 1'b0, 1'b0);
    start_i = 1'b0;
    tick();
    tick();
    snap(3'd3, 8'd0, 4'd0, 1'b0, 1'b0);
    tick();
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cyc %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0]   p;
    logic [W-1:0] exp_ev;
    snap_t        s;
    p = {dp_if.spawn, dp_if.drop, dp_if.move_left, dp_if.move_right, dp_if.rotate, dp_if.lock};
    if (nRst_i === 1'b1 && p != 6'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse actual=cyc%0d/%b required=none", cyc, p);
      end else begin
        exp_ev = exp_q.pop_front();
        if ({16'(cyc), p} !== exp_ev) begin
          failures++;
          $display("FAIL pulse_event actual=cyc%0d/%b required=cyc%0d/%b",
                   cyc, p, exp_ev[W-1:6], exp_ev[5:0]);
        end
      end
    end
    while (snap_q.size() != 0 && snap_q[0].at == 16'(cyc)) begin
      s = snap_q.pop_front();
      cmp("state_o", 32'(state_o), 32'(s.st));
      cmp("lines_o", 32'(lines_o), 32'(s.lines));
      cmp("level_o", 32'(level_o), 32'(s.lvl));
      cmp("clear_req_o", 32'(dp_if.clear_req), 32'(s.creq));
      if (s.chk_p) cmp("pulses_idle", 32'(p), 32'd0);
    end
    if (done) begin
      cmp("pending_pulse_events", exp_q.size(), 0);
      cmp("pending_snapshots", snap_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
